// File: rtl/mio_pkg.sv
// Shared constants for the MIO responder: IO region base, IO register offsets
// and the responder FSM encoding.
package mio_pkg;

    localparam logic [3:0]  IO_BASE = 4'hF;

    localparam logic [27:0] OFF_LED = 28'h000_0000;
    localparam logic [27:0] OFF_SW  = 28'h000_0004;
    localparam logic [27:0] OFF_CMP = 28'h000_0008;
    localparam logic [27:0] OFF_CNT = 28'h000_000C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_io(input logic [31:0] addr);
        return addr[31:28] == IO_BASE;
    endfunction

endpackage

// File: rtl/mio_timer.sv
// Compare timer: CNT counts up while CMP is non-zero, wraps to 0 on a match and
// raises a pending interrupt that is retired by an Iack pulse.
module mio_timer
    import mio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmp_we,
    input  logic [31:0] cmp_wdata,
    input  logic        cnt_clr,
    input  logic        iack,
    output logic [31:0] cmp,
    output logic [31:0] cnt,
    output logic        ireq
);

    logic pending;
    logic match;

    assign match = (cmp != 32'd0) && (cnt == cmp);
    assign ireq  = pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp     <= '0;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            if (cmp_we)
                cmp <= cmp_wdata;

            if (cnt_clr)
                cnt <= '0;
            else if (cmp != 32'd0)
                cnt <= match ? 32'd0 : cnt + 32'd1;

            // A new match outranks Iack; a CNT write suppresses the match.
            if (match && !cnt_clr)
                pending <= 1'b1;
            else if (iack)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/mio_responder.sv
// MIO bus responder: decodes CPU requests into block RAM or IO registers,
// inserts per-region wait states and answers with a one-cycle MIO_ready.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for MemRead/MemWrite; accepts, writes RAM/IO registers
//   WAIT    | counting down region wait states
//   RESP    | MIO_ready high, data2CPU valid; always returns to IDLE
module mio_responder
    import mio_pkg::*;
#(
    parameter int RAM_AW   = 12,
    parameter int RAM_WAIT = 1,
    parameter int IO_WAIT  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       Data_out,
    output logic [31:0]       data2CPU,
    output logic              MIO_ready,
    output logic              Ireq,
    input  logic              Iack,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [31:0]       sw_in,
    output logic [31:0]       led_out
);

    localparam logic [7:0] RAM_WAIT_C = 8'(RAM_WAIT);
    localparam logic [7:0] IO_WAIT_C  = 8'(IO_WAIT);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_nxt;
    logic [7:0]  wait_load;
    logic        rd_q, io_q;
    logic        cur_rd, cur_io;
    logic        load_data;
    logic        req, accept, wr_only, io_sel, io_wr;
    logic [27:0] io_off;
    logic [31:0] io_rdata, resp_data;
    logic [31:0] cmp, cnt;
    logic        unused_bits;

    assign unused_bits = ^addr_bus[1:0];

    assign req       = MemRead | MemWrite;
    assign wr_only   = MemWrite & ~MemRead;
    assign io_sel    = is_io(addr_bus);
    assign io_off    = {addr_bus[27:2], 2'b00};
    assign accept    = (state == ST_IDLE) & req;
    assign wait_load = io_sel ? IO_WAIT_C : RAM_WAIT_C;

    assign ram_addr  = addr_bus[RAM_AW+1:2];
    assign ram_din   = Data_out;
    assign ram_we    = ~reset & accept & wr_only & ~io_sel;
    assign io_wr     = ~reset & accept & wr_only & io_sel;
    assign MIO_ready = (state == ST_RESP);

    // Live request decode on the IDLE->RESP shortcut, latched copy otherwise.
    assign cur_rd = (state == ST_IDLE) ? MemRead : rd_q;
    assign cur_io = (state == ST_IDLE) ? io_sel  : io_q;

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        load_data = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    wait_nxt = wait_load;
                    if (wait_load != 8'd0) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_RESP;
                        load_data = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                wait_nxt = wait_cnt - 8'd1;
                if (wait_cnt <= 8'd1) begin
                    state_nxt = ST_RESP;
                    load_data = 1'b1;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        io_rdata = '0;
        case (io_off)
            OFF_LED: io_rdata = led_out;
            OFF_SW:  io_rdata = sw_in;
            OFF_CMP: io_rdata = cmp;
            OFF_CNT: io_rdata = cnt;
            default: io_rdata = '0;
        endcase
    end

    always_comb begin
        resp_data = '0;
        if (cur_rd)
            resp_data = cur_io ? io_rdata : ram_dout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            rd_q     <= 1'b0;
            io_q     <= 1'b0;
            data2CPU <= '0;
            led_out  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (accept) begin
                rd_q <= MemRead;
                io_q <= io_sel;
            end
            if (load_data)
                data2CPU <= resp_data;
            if (io_wr && io_off == OFF_LED)
                led_out <= Data_out;
        end
    end

    mio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .cmp_we    (io_wr && io_off == OFF_CMP),
        .cmp_wdata (Data_out),
        .cnt_clr   (io_wr && io_off == OFF_CNT),
        .iack      (Iack),
        .cmp       (cmp),
        .cnt       (cnt),
        .ireq      (Ireq)
    );

endmodule

// File: tb/tb_mio_responder.sv
// Directed bench for mio_responder with default parameters (RAM_WAIT=1,
// IO_WAIT=0) and a behavioural 1-cycle-latency block RAM.
module tb_mio_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, Iack;
    logic [31:0] addr_bus, Data_out, data2CPU, ram_din, ram_dout, sw_in, led_out;
    logic        MIO_ready, Ireq, ram_we;
    logic [11:0] ram_addr;

    logic [31:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    mio_responder #(.RAM_AW(12), .RAM_WAIT(1), .IO_WAIT(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr_bus  (addr_bus),
        .Data_out  (Data_out),
        .data2CPU  (data2CPU),
        .MIO_ready (MIO_ready),
        .Ireq      (Ireq),
        .Iack      (Iack),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .sw_in     (sw_in),
        .led_out   (led_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Starts in an IDLE cycle at a negedge; returns at the first cycle after RESP.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat, input logic [31:0] exp_data,
                          input int exp_we);
        int lat;
        int we_cnt;
        logic [31:0] got;
        lat = -1;
        we_cnt = 0;
        got = '0;
        MemRead = rd;
        MemWrite = wr;
        addr_bus = a;
        Data_out = d;
        #1;
        for (int c = 0; c <= exp_lat + 3 && lat < 0; c++) begin
            if (c > 0)
                step(1);
            if (ram_we)
                we_cnt++;
            if (MIO_ready) begin
                lat = c;
                got = data2CPU;
            end
        end
        MemRead = 1'b0;
        MemWrite = 1'b0;
        step(1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, got, exp_data);
        chk({tag, "_we"}, 32'(we_cnt), 32'(exp_we));
        chk({tag, "_pulse"}, {31'd0, MIO_ready}, 32'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 4096; i++)
            mem[i] = '0;
        mem[5] = 32'hDEAD_BEEF;
        reset = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        Iack = 1'b0;
        addr_bus = '0;
        Data_out = '0;
        sw_in = 32'h0000_003C;

        step(3);
        chk("rst_ready", {31'd0, MIO_ready}, 32'd0);
        chk("rst_data", data2CPU, 32'd0);
        chk("rst_ireq", {31'd0, Ireq}, 32'd0);
        chk("rst_led", led_out, 32'd0);
        reset = 1'b0;
        step(1);

        access("ram_rd5", 1'b1, 1'b0, 32'h0000_0014, 32'd0, 2, 32'hDEAD_BEEF, 0);
        access("ram_wr", 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 2, 32'd0, 1);
        access("ram_rdback", 1'b1, 1'b0, 32'h0000_0020, 32'd0, 2, 32'h1234_5678, 0);

        access("led_wr", 1'b0, 1'b1, 32'hF000_0000, 32'h0000_00A5, 1, 32'd0, 0);
        chk("led_out", led_out, 32'h0000_00A5);
        access("sw_rd", 1'b1, 1'b0, 32'hF000_0004, 32'd0, 1, 32'h0000_003C, 0);
        access("led_rd", 1'b1, 1'b0, 32'hF000_0000, 32'd0, 1, 32'h0000_00A5, 0);

        access("both", 1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_0000, 2, 32'h1234_5678, 0);
        access("both_rd", 1'b1, 1'b0, 32'h0000_0020, 32'd0, 2, 32'h1234_5678, 0);
        access("unm_wr", 1'b0, 1'b1, 32'hF000_0010, 32'h0000_00FF, 1, 32'd0, 0);
        access("unm_rd", 1'b1, 1'b0, 32'hF000_0010, 32'd0, 1, 32'd0, 0);
        chk("led_keep", led_out, 32'h0000_00A5);

        // CMP=3: CNT runs 0..3, match every 4 cycles.
        access("cmp_wr", 1'b0, 1'b1, 32'hF000_0008, 32'd3, 1, 32'd0, 0);
        k = 0;
        while (!Ireq && k < 10) begin
            step(1);
            k++;
        end
        chk("ireq_rise", 32'(k), 32'd3);
        step(2);
        chk("ireq_hold", {31'd0, Ireq}, 32'd1);
        Iack = 1'b1;
        step(1);
        Iack = 1'b0;
        chk("ireq_ack", {31'd0, Ireq}, 32'd0);
        step(4);
        chk("ireq_rearm", {31'd0, Ireq}, 32'd1);
        Iack = 1'b1;
        step(1);
        Iack = 1'b0;
        chk("ireq_coinc", {31'd0, Ireq}, 32'd1);
        step(1);
        access("cnt_rd", 1'b1, 1'b0, 32'hF000_000C, 32'd0, 1, 32'd1, 0);

        access("cmp_wr100", 1'b0, 1'b1, 32'hF000_0008, 32'd100, 1, 32'd0, 0);
        step(20);
        access("cnt_clr", 1'b0, 1'b1, 32'hF000_000C, 32'hFFFF_FFFF, 1, 32'd0, 0);
        access("cnt_rd2", 1'b1, 1'b0, 32'hF000_000C, 32'd0, 1, 32'd1, 0);
        chk("ireq_pend", {31'd0, Ireq}, 32'd1);
        Iack = 1'b1;
        step(1);
        Iack = 1'b0;
        chk("ireq_clr", {31'd0, Ireq}, 32'd0);

        // Abort a RAM read in WAIT; hold a RAM write request during reset.
        MemRead = 1'b1;
        addr_bus = 32'h0000_0014;
        step(1);
        reset = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b1;
        addr_bus = 32'h0000_0040;
        Data_out = 32'h0000_0055;
        step(1);
        chk("arst_we", {31'd0, ram_we}, 32'd0);
        chk("arst_ready", {31'd0, MIO_ready}, 32'd0);
        chk("arst_data", data2CPU, 32'd0);
        chk("arst_led", led_out, 32'd0);
        chk("arst_ireq", {31'd0, Ireq}, 32'd0);
        step(1);
        chk("arst_ready2", {31'd0, MIO_ready}, 32'd0);
        MemWrite = 1'b0;
        reset = 1'b0;
        step(1);
        chk("arst_ready3", {31'd0, MIO_ready}, 32'd0);
        access("arst_nowr", 1'b1, 1'b0, 32'h0000_0040, 32'd0, 2, 32'd0, 0);
        access("arst_rd5", 1'b1, 1'b0, 32'h0000_0014, 32'd0, 2, 32'hDEAD_BEEF, 0);
        access("arst_cmp", 1'b1, 1'b0, 32'hF000_0008, 32'd0, 1, 32'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mio_responder.md
# mio_responder

Bus responder at the memory/IO end of the multi-cycle CPU's MIO interface. It accepts the CPU controller's MemRead/MemWrite requests and decodes the address into a block-RAM region or a small IO register region. It inserts per-region wait states and returns read data with a single-cycle MIO_ready pulse. It also owns a compare timer that drives the CPU's Ireq and retires it on Iack.

## Interface
Parameters:
- RAM_AW, 12, RAM word-address width; RAM region holds 2^RAM_AW words.
- RAM_WAIT, 1, extra cycles before MIO_ready on RAM accesses; must be ≥1.
- IO_WAIT, 0, extra cycles before MIO_ready on IO accesses; ≥0.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- MemRead  in  1  read request, held until MIO_ready sampled high
- MemWrite  in  1  write request, held until MIO_ready sampled high
- addr_bus  in  32  byte address, stable while request held
- Data_out  in  32  CPU write data, stable while MemWrite held
- data2CPU  out  32  read data, valid while MIO_ready=1
- MIO_ready  out  1  one-cycle completion pulse
- Ireq  out  1  level interrupt request
- Iack  in  1  one-cycle interrupt acknowledge
- ram_addr  out  RAM_AW  = addr_bus[RAM_AW+1:2], combinational
- ram_din  out  32  = Data_out, combinational
- ram_we  out  1  RAM write strobe
- ram_dout  in  32  synchronous RAM read data, 1-cycle latency
- sw_in  in  32  switch inputs
- led_out  out  32  LED register

## Operation
- Region: addr_bus[31:28]==4'hF → IO, else RAM. addr_bus[1:0] ignored (word bus only; halfword handling stays in CPU).
- FSM states: IDLE, WAIT, RESP.
  - IDLE: any of MemRead/MemWrite high → latch region/op and load wait counter with the region's wait count. Go to WAIT if that count >0, else to RESP.
  - WAIT: decrement; at 1 → RESP.
  - RESP: MIO_ready=1, data2CPU valid, → IDLE.
- Request detection happens only in IDLE. A request still asserted during RESP is not re-accepted.
- ram_we = IDLE & MemWrite & !MemRead & RAM region. It is high for exactly one cycle per write.
- MemRead and MemWrite both high: treated as a read, no write performed.
- data2CPU loads on the WAIT→RESP or IDLE→RESP edge from ram_dout (RAM) or the IO mux (IO). Writes return data2CPU=0.
- IO map (offset from 0xF000_0000):
  - 0x0 LED: RW, drives led_out.
  - 0x4 SW: RO, sw_in.
  - 0x8 CMP: RW, compare value.
  - 0xC CNT: RO on read; any write clears it to 0.
  - Other offsets: read 0, write ignored.
  - IO writes take effect on the IDLE→ edge.
- Timer behaviour:
  - CMP==0: CNT frozen.
  - Otherwise CNT+1 each cycle; when CNT==CMP, CNT←0 and pending←1.
  - Ireq=pending. Iack=1 clears pending.
  - Iack in the same cycle as a new match: pending stays 1.
  - A CNT write in the same cycle as a match: the write wins, no pending set.

## Timing
- Request first high in IDLE in cycle n:
  - RAM: MIO_ready high in cycle n+1+RAM_WAIT.
  - IO: MIO_ready high in cycle n+1+IO_WAIT.
- Back-to-back: the cycle after RESP is IDLE and may accept the next request immediately. Example: IF fetch directly following MEM_WD.
- RAM write commits at end of cycle n. A RAM read samples ram_addr at end of cycle n; ram_dout is captured at the end of cycle n+RAM_WAIT.
- Reset values: MIO_ready=0, data2CPU=0, Ireq=0, led_out=0, CMP=0, CNT=0, state=IDLE. ram_we=0 while reset is high.
- Reset mid-access: the transaction is aborted, no MIO_ready is issued, and a write is not committed unless its IDLE cycle already completed.

## Structure
- Package mio_pkg: IO base (4'hF), register offsets, state encoding localparams.
- Sub-module mio_timer: CNT/CMP/pending, Ireq/Iack handshake, and the CNT write-clear port.
- Top mio_responder: FSM, wait counter, address decode, data mux, LED register.

## Test plan
- RAM read, RAM_WAIT=1: preload word 5 = 0xDEADBEEF, MemRead with addr 0x14 from cycle 0 → MIO_ready only in cycle 2, data2CPU=0xDEADBEEF.
- RAM write then read: MemWrite addr 0x20, Data_out 0x12345678 → ram_we one cycle, MIO_ready cycle 2. Next-cycle MemRead 0x20 → 0x12345678.
- IO, IO_WAIT=0: write 0xF000_0000 with 0xA5 → MIO_ready in cycle 1, led_out=0xA5. Read 0xF000_0004 with sw_in=0x3C → data2CPU=0x3C.
- Timer: CMP=3 → Ireq rises 4 cycles after CNT starts and holds until an Iack pulse, then falls next cycle. Iack coincident with the next match → Ireq stays 1.
- Both MemRead and MemWrite high on a RAM address → ram_we never asserted, MIO_ready pulses once with read data. Unmapped IO offset 0x10 reads 0.
- Reset asserted in WAIT → MIO_ready stays 0, state IDLE, all outputs at reset values.
